// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Speculative branch predictor and E-stage resolver for the RV32I 5-stage pipeline.
// Fetch side: combinational direction/target lookup in a direct-mapped BTB with
// 2-bit saturating counters. Execute side: misprediction detection, redirect PC
// and table training on every resolved control-flow instruction.
//
// Optional feature: define BPU_GSHARE_EN to index the counter table with
// pc-index XOR global history (gshare). This adds a GHR plus the F_ghr/E_ghr
// ports. With the macro undefined the unit is a plain PC-indexed bimodal
// predictor.

module branch_predict_unit #(
    parameter int         IDX_W     = 6,
    parameter logic [1:0] RESET_CTR = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    // fetch side
    input  logic [31:0]      F_pc,
    output logic             F_pred_taken,
    output logic [31:0]      F_pred_target,
    // execute side
    input  logic             E_valid,
    input  logic             E_is_branch,
    input  logic             E_is_jump,
    input  logic [31:0]      E_pc,
    input  logic             E_actual_taken,
    input  logic [31:0]      E_actual_target,
    input  logic             E_pred_taken,
    input  logic [31:0]      E_pred_target,
    output logic             branch_jump,
    output logic             mispre,
    output logic [31:0]      E_redirect_pc
`ifdef BPU_GSHARE_EN
    ,
    output logic [IDX_W-1:0] F_ghr,
    input  logic [IDX_W-1:0] E_ghr
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    // One BTB line: the counter lives in its own array because under gshare
    // it is indexed differently from the tag/target.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];
    logic [1:0] ctr [ENTRIES];

    // ------------------------------------------------------------------
    // Index / tag extraction
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_cidx;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic [IDX_W-1:0] e_cidx;

    assign f_idx = F_pc[IDX_W+1:2];
    assign f_tag = F_pc[31:IDX_W+2];
    assign e_idx = E_pc[IDX_W+1:2];
    assign e_tag = E_pc[31:IDX_W+2];

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    assign F_ghr  = ghr;
    assign f_cidx = f_idx ^ ghr;
    assign e_cidx = e_idx ^ E_ghr;
`else
    assign f_cidx = f_idx;
    assign e_cidx = e_idx;
`endif

    // ------------------------------------------------------------------
    // Fetch-side lookup (reads pre-update contents on a same-cycle update)
    // ------------------------------------------------------------------
    btb_entry_t f_entry;
    logic       f_hit;

    assign f_entry       = btb[f_idx];
    assign f_hit         = f_entry.valid && (f_entry.tag == f_tag);
    assign F_pred_taken  = f_hit && ctr[f_cidx][1];
    assign F_pred_target = F_pred_taken ? f_entry.target : F_pc + 32'd4;

    // ------------------------------------------------------------------
    // Execute-side resolution
    // ------------------------------------------------------------------
    logic dir_wrong;
    logic tgt_wrong;

    assign branch_jump   = E_valid && (E_is_branch || E_is_jump);
    assign dir_wrong     = (E_pred_taken != E_actual_taken);
    assign tgt_wrong     = E_actual_taken && E_pred_taken && (E_pred_target != E_actual_target);
    assign mispre        = branch_jump && (dir_wrong || tgt_wrong);
    assign E_redirect_pc = E_actual_taken ? E_actual_target : E_pc + 32'd4;

    // ------------------------------------------------------------------
    // Training: hit detection and next counter value for the E instruction
    // ------------------------------------------------------------------
    btb_entry_t e_entry;
    logic       e_hit;
    logic [1:0] e_ctr;
    logic [1:0] e_ctr_nxt;

    assign e_entry = btb[e_idx];
    assign e_hit   = e_entry.valid && (e_entry.tag == e_tag);
    assign e_ctr   = ctr[e_cidx];

    // Compute the trained counter value: jumps pin to strongly taken,
    // branches saturate up/down; a miss allocates at 10 (branch) / 11 (jump).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        e_ctr_nxt = e_ctr;
        if (!e_hit) begin
            e_ctr_nxt = E_is_jump ? 2'b11 : 2'b10;
        end else if (E_is_jump) begin
            e_ctr_nxt = 2'b11;
        end else if (E_actual_taken) begin
            e_ctr_nxt = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'd1;
        end else begin
            e_ctr_nxt = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'd1;
        end
    end

    // Decide whether the BTB line and/or counter are written this cycle.
    logic btb_we;
    logic ctr_we;

    always_comb begin
        btb_we = 1'b0;
        ctr_we = 1'b0;
        if (branch_jump) begin
            if (e_hit) begin
                ctr_we = 1'b1;
                btb_we = E_is_jump || E_actual_taken;
            end else if (E_actual_taken) begin
                ctr_we = 1'b1;
                btb_we = 1'b1;
            end
        end
    end

    // Table state: reset clears every line, otherwise apply at most one update.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the tables are reset explicitly (not left as uninitialised RAM)
        // because a reset must make every lookup miss immediately.
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '0;
                ctr[i] <= RESET_CTR;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // read in this cycle sees pre-edge values.
            if (btb_we) begin
                btb[e_idx] <= '{valid: 1'b1, tag: e_tag, target: E_actual_target};
            end
            if (ctr_we) begin
                ctr[e_cidx] <= e_ctr_nxt;
            end
        end
    end

`ifdef BPU_GSHARE_EN
    // Global history shifts in the outcome of each resolved conditional branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (branch_jump && E_is_branch && !E_is_jump) begin
            ghr <= {ghr[IDX_W-2:0], E_actual_taken};
        end
    end
`endif

endmodule
